// File: rtl/kernel_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// kernel_run_ctrl_if
// Block-level ap_ctrl_hs handshake between the run sequencer and an HLS kernel.
//   ap_start : sequencer -> kernel, start request (held until ap_ready)
//   ap_ready : kernel -> sequencer, inputs accepted
//   ap_done  : kernel -> sequencer, single-cycle run-complete pulse
// Modports: master = sequencer side, slave = kernel side.
// -----------------------------------------------------------------------------
interface kernel_run_ctrl_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;

    modport master (
        output ap_start,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        output ap_ready,
        output ap_done
    );
endinterface

// File: rtl/kernel_run_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_run_ctrl
// Run sequencer for an ap_ctrl_hs HLS kernel inside the power-measurement
// wrapper. A rising VIO start probe launches a session of back-to-back kernel
// runs separated by a programmable idle gap; each completed run advances the
// dataset index, strobes a RAM bank swap and records run latency.
//
// Ports
//   ap_clk, ap_rst : clock (rising edge), asynchronous active-high reset
//   probe_start    : session request level from VIO (asynchronous)
//   ctrl           : ap_start / ap_ready / ap_done handshake (master modport)
//   dataset_idx    : dataset presented to the kernel RAMs
//   ds_swap        : one-cycle bank-swap strobe, one cycle after ap_done
//   run_cnt        : runs completed in this session (saturating)
//   last_latency   : cycle count of the most recent run
//   max_latency    : largest run latency in this session
//   busy           : session in progress (START / WAIT_DONE / GAP)
//   all_done       : session finished, waiting for probe_start to fall
// -----------------------------------------------------------------------------
module kernel_run_ctrl #(
    parameter int unsigned RUN_NUM     = 1024,
    parameter int unsigned DATASET_NUM = 8,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    localparam int unsigned DS_W       = $clog2(DATASET_NUM)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  probe_start,
    kernel_run_ctrl_if.master     ctrl,
    output logic [DS_W-1:0]       dataset_idx,
    output logic                  ds_swap,
    output logic [15:0]           run_cnt,
    output logic [CNT_WIDTH-1:0]  last_latency,
    output logic [CNT_WIDTH-1:0]  max_latency,
    output logic                  busy,
    output logic                  all_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    // Gap counter value on which the GAP decision is taken; a zero gap still
    // spends one cycle in GAP.
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 32'd0) ? 32'd0 : GAP_CYCLES - 32'd1;

    function automatic logic [CNT_WIDTH-1:0] lat_sat_inc(input logic [CNT_WIDTH-1:0] v);
        lat_sat_inc = (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [15:0] run_sat_inc(input logic [15:0] v);
        run_sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DS_W-1:0] ds_wrap_inc(input logic [DS_W-1:0] v);
        ds_wrap_inc = (v == DS_W'(DATASET_NUM - 32'd1)) ? {DS_W{1'b0}} : v + DS_W'(1);
    endfunction

    state_t                 state_r, state_nx_s;
    logic                   sync1_r, sync2_r, sync_prev_r;
    logic [1:0]             fill_r;
    logic                   go_s, stop_s, in_run_s, done_acc_s, start_entry_s;
    logic                   gap_last_s, run_limit_s, stop_seen_r;
    logic [31:0]            gap_cnt_r;
    logic [CNT_WIDTH-1:0]   lat_cnt_r, lat_nx_s, last_lat_r, max_lat_r;
    logic [DS_W-1:0]        dataset_idx_r;
    logic [15:0]            run_cnt_r;
    logic                   ap_start_r, ds_swap_r, busy_r, all_done_r;

    // Probe synchronizer plus edge-detect copy. The copy is held high until the
    // synchronizer has refilled after reset, so a probe left high across reset
    // is not mistaken for a new request.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            fill_r      <= 2'b00;
            sync_prev_r <= 1'b1;
        end else begin
            sync1_r     <= probe_start;
            sync2_r     <= sync1_r;
            fill_r      <= {fill_r[0], 1'b1};
            sync_prev_r <= sync2_r | ~fill_r[1];
        end
    end

    assign go_s          = sync2_r & ~sync_prev_r;
    assign stop_s        = ~sync2_r;
    assign in_run_s      = (state_r == S_START) || (state_r == S_WAIT_DONE);
    assign done_acc_s    = in_run_s && ctrl.ap_done;
    assign start_entry_s = (state_nx_s == S_START) && (state_r != S_START);
    assign gap_last_s    = (gap_cnt_r == GAP_LAST);
    assign run_limit_s   = (RUN_NUM != 32'd0) && ({16'd0, run_cnt_r} == RUN_NUM);
    assign lat_nx_s      = lat_sat_inc(lat_cnt_r);

    // Next-state decode for the session FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (go_s) state_nx_s = S_START;
                else      state_nx_s = S_IDLE;
            end
            S_START: begin
                // A done in START (with or without ready) ends the run directly.
                if (ctrl.ap_done)       state_nx_s = S_GAP;
                else if (ctrl.ap_ready) state_nx_s = S_WAIT_DONE;
                else                    state_nx_s = S_START;
            end
            S_WAIT_DONE: begin
                if (ctrl.ap_done) state_nx_s = S_GAP;
                else              state_nx_s = S_WAIT_DONE;
            end
            S_GAP: begin
                if (gap_last_s) begin
                    if (run_limit_s || stop_seen_r || stop_s) state_nx_s = S_FINISH;
                    else                                       state_nx_s = S_START;
                end else begin
                    state_nx_s = S_GAP;
                end
            end
            S_FINISH: begin
                if (stop_s) state_nx_s = S_IDLE;
                else        state_nx_s = S_FINISH;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register and state-decoded outputs, registered from the next state
    // so they change on the same edge as the state.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r    <= S_IDLE;
            ap_start_r <= 1'b0;
            busy_r     <= 1'b0;
            all_done_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ap_start_r <= (state_nx_s == S_START);
            busy_r     <= (state_nx_s == S_START) || (state_nx_s == S_WAIT_DONE) ||
                          (state_nx_s == S_GAP);
            all_done_r <= (state_nx_s == S_FINISH);
        end
    end

    // Gap timer, run latency counter and the sticky stop flag for the current run.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            gap_cnt_r   <= 32'd0;
            lat_cnt_r   <= {CNT_WIDTH{1'b0}};
            stop_seen_r <= 1'b0;
        end else begin
            gap_cnt_r <= (state_r == S_GAP) ? gap_cnt_r + 32'd1 : 32'd0;
            if (start_entry_s)  lat_cnt_r <= {CNT_WIDTH{1'b0}};
            else if (in_run_s)  lat_cnt_r <= lat_nx_s;
            if (start_entry_s)                      stop_seen_r <= 1'b0;
            else if ((state_r != S_IDLE) && stop_s) stop_seen_r <= 1'b1;
        end
    end

    // Per-run bookkeeping. The captured latency includes the done cycle itself.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ds_swap_r     <= 1'b0;
            dataset_idx_r <= {DS_W{1'b0}};
            run_cnt_r     <= 16'd0;
            last_lat_r    <= {CNT_WIDTH{1'b0}};
            max_lat_r     <= {CNT_WIDTH{1'b0}};
        end else begin
            ds_swap_r <= done_acc_s;
            if ((state_r == S_IDLE) && go_s) begin
                dataset_idx_r <= {DS_W{1'b0}};
                run_cnt_r     <= 16'd0;
                last_lat_r    <= {CNT_WIDTH{1'b0}};
                max_lat_r     <= {CNT_WIDTH{1'b0}};
            end else if (done_acc_s) begin
                dataset_idx_r <= ds_wrap_inc(dataset_idx_r);
                run_cnt_r     <= run_sat_inc(run_cnt_r);
                last_lat_r    <= lat_nx_s;
                max_lat_r     <= (lat_nx_s > max_lat_r) ? lat_nx_s : max_lat_r;
            end
        end
    end

    assign ctrl.ap_start = ap_start_r;
    assign dataset_idx   = dataset_idx_r;
    assign ds_swap       = ds_swap_r;
    assign run_cnt       = run_cnt_r;
    assign last_latency  = last_lat_r;
    assign max_latency   = max_lat_r;
    assign busy          = busy_r;
    assign all_done      = all_done_r;

endmodule
